// File: rtl/fpga_keypad_reader_if.sv
// CPU-side register bus of the pushbutton reader: page select, access
// direction, address, write data, read data and the FIFO interrupt.
interface fpga_keypad_reader_if;
    logic       cs;
    logic       read_en;
    logic [7:0] addr;
    logic [7:0] din;
    logic [7:0] dout;
    logic       irq;

    modport master (
        output cs,
        output read_en,
        output addr,
        output din,
        input  dout,
        input  irq
    );

    modport slave (
        input  cs,
        input  read_en,
        input  addr,
        input  din,
        output dout,
        output irq
    );
endinterface

// File: rtl/fpga_keypad_reader.sv
// Pushbutton input peripheral: synchronizes and debounces the raw buttons,
// turns press edges into key codes queued in a small FIFO, and exposes the
// queue, status and live button levels as memory-mapped registers.
module fpga_keypad_reader #(
    parameter int NUM_KEYS    = 21,
    parameter int DEB_CYCLES  = 16,
    parameter int FIFO_DEPTH  = 8,
    parameter int STATUS_ADDR = 11,
    parameter int KEY_ADDR    = 12
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_KEYS-1:0] pb,
    fpga_keypad_reader_if.slave bus
);

    // Counter holds 0..DEB_CYCLES-1; reaching DEB_CYCLES is the accept event.
    localparam int DEB_W = (DEB_CYCLES < 2) ? 1 : $clog2(DEB_CYCLES);
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    localparam logic [7:0] LIVE0_ADDR = 8'd13;
    localparam logic [7:0] LIVE1_ADDR = 8'd14;
    localparam logic [7:0] LIVE2_ADDR = 8'd15;

    logic [NUM_KEYS-1:0] sync_p0;
    logic [NUM_KEYS-1:0] sync_p1;
    logic [NUM_KEYS-1:0] stable;
    logic [NUM_KEYS-1:0] stable_d;
    logic [NUM_KEYS-1:0] pending;
    logic [NUM_KEYS-1:0] press;
    logic [NUM_KEYS-1:0] clr;
    logic [DEB_W-1:0]    cnt [NUM_KEYS];

    logic [4:0]          fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [3:0]          count;
    logic [3:0]          count_next;
    logic                overflow;
    logic                irq_q;

    logic                acc_rd;
    logic                acc_wr;
    logic                pop;
    logic                push;
    logic                flush;
    logic                ovf_clr;
    logic                ovf_set;
    logic                full;
    logic [4:0]          enq_code;
    logic [31:0]         stable_ext;
    logic [7:0]          rdata;
    logic                unused_bits;

    // Two-flop synchronizer on every raw button input.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
        end else begin
            sync_p0 <= pb;
            sync_p1 <= sync_p0;
        end
    end

    // Per-key debounce: accept a new level only after DEB_CYCLES consecutive disagreeing samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            stable   <= '0;
            stable_d <= '0;
            for (int i = 0; i < NUM_KEYS; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            stable_d <= stable;
            for (int i = 0; i < NUM_KEYS; i++) begin
                if (sync_p1[i] == stable[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == DEB_W'(DEB_CYCLES - 1)) begin
                    stable[i] <= sync_p1[i];
                    cnt[i]    <= '0;
                end else begin
                    cnt[i] <= cnt[i] + DEB_W'(1);
                end
            end
        end
    end

    assign press = stable & ~stable_d;

    // Access decode, lowest-index pending selection and FIFO bookkeeping.
    always_comb begin
        acc_rd   = bus.cs & bus.read_en;
        acc_wr   = bus.cs & ~bus.read_en;
        full     = (count == 4'(FIFO_DEPTH));
        pop      = acc_rd && (bus.addr == 8'(KEY_ADDR)) && (count != 4'd0);
        flush    = acc_wr && (bus.addr == 8'(STATUS_ADDR)) && bus.din[0];
        ovf_clr  = acc_wr && (bus.addr == 8'(STATUS_ADDR)) && bus.din[1];
        enq_code = 5'd0;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (pending[i]) begin
                enq_code = 5'(i);
            end
        end
        // A pop in the same cycle frees the slot, so a full FIFO can still accept.
        push     = (pending != '0) && (!full || pop) && !flush;
        clr      = push ? (NUM_KEYS'(1) << enq_code) : '0;
        ovf_set  = ((press & pending) != '0) && !flush;
        if (flush) begin
            count_next = 4'd0;
        end else begin
            count_next = count + {3'd0, push} - {3'd0, pop};
        end
    end

    // Pending mask, FIFO pointers, occupancy, overflow flag and interrupt.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending  <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            if (flush) begin
                pending <= '0;
                wr_ptr  <= '0;
                rd_ptr  <= '0;
            end else begin
                pending <= (pending & ~clr) | press;
                if (push) begin
                    wr_ptr <= wr_ptr + PTR_W'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
            end
            count <= count_next;
            if (ovf_set) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
            irq_q <= (count_next != 4'd0);
        end
    end

    // Key-code storage; contents are only meaningful between the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= enq_code;
        end
    end

    assign stable_ext = 32'(stable);

    // Register read mux; zero outside the page, on writes and on unmapped addresses.
    always_comb begin
        rdata = 8'h00;
        if (acc_rd) begin
            if (bus.addr == 8'(STATUS_ADDR)) begin
                rdata = {count, (pending != '0), full, overflow, (count != 4'd0)};
            end else if (bus.addr == 8'(KEY_ADDR)) begin
                rdata = (count != 4'd0) ? {3'd0, fifo_mem[rd_ptr]} : 8'hFF;
            end else if (bus.addr == LIVE0_ADDR) begin
                rdata = stable_ext[7:0];
            end else if (bus.addr == LIVE1_ADDR) begin
                rdata = stable_ext[15:8];
            end else if (bus.addr == LIVE2_ADDR) begin
                rdata = stable_ext[23:16];
            end
        end
    end

    assign bus.dout    = rdata;
    assign bus.irq     = irq_q;
    assign unused_bits = ^{bus.din[7:2], stable_ext[31:24]};

endmodule

// File: tb/tb_fpga_keypad_reader.sv
// Directed bench for the pushbutton reader with a queue-based reference model
// compared against the register bus on every cycle after the first reset.
module tb_fpga_keypad_reader;

    localparam int NK    = 21;
    localparam int DEB   = 16;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [NK-1:0] pb;

    always #5 clk = ~clk;

    fpga_keypad_reader_if bus_if ();

    fpga_keypad_reader #(
        .NUM_KEYS   (NK),
        .DEB_CYCLES (DEB),
        .FIFO_DEPTH (DEPTH),
        .STATUS_ADDR(11),
        .KEY_ADDR   (12)
    ) dut (
        .clk(clk),
        .rst(rst),
        .pb (pb),
        .bus(bus_if)
    );

    int ncmp  = 0;
    int nfail = 0;

    // Reference model state
    bit            mvalid = 1'b0;
    logic [NK-1:0] m_stable;
    logic [NK-1:0] m_pending;
    logic [NK-1:0] m_press;
    bit            m_ovf;
    bit            m_irq;
    logic [4:0]    m_fifo[$];
    logic [NK-1:0] m_hist[$];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        ncmp++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] model_dout();
        logic [31:0] live;
        live = 32'(m_stable);
        if (!(bus_if.cs && bus_if.read_en)) return 8'h00;
        case (bus_if.addr)
            8'd11: return {4'(m_fifo.size()), (m_pending != '0), (m_fifo.size() == DEPTH),
                           m_ovf, (m_fifo.size() != 0)};
            8'd12: return (m_fifo.size() != 0) ? {3'd0, m_fifo[0]} : 8'hFF;
            8'd13: return live[7:0];
            8'd14: return live[15:8];
            8'd15: return live[23:16];
            default: return 8'h00;
        endcase
    endfunction

    // Model: stable flips once the last DEB synchronized samples all disagree with it
    always @(posedge clk) begin
        if (rst) begin
            mvalid    = 1'b1;
            m_stable  = '0;
            m_pending = '0;
            m_press   = '0;
            m_ovf     = 1'b0;
            m_irq     = 1'b0;
            m_fifo.delete();
            m_hist.delete();
            for (int i = 0; i < DEB + 2; i++) m_hist.push_back('0);
        end else if (mvalid) begin
            bit            pop, flush, clr_ov, ovf_hit, all_diff;
            int            k;
            logic [NK-1:0] nstable;
            pop     = bus_if.cs && bus_if.read_en && bus_if.addr == 8'd12 && m_fifo.size() != 0;
            flush   = bus_if.cs && !bus_if.read_en && bus_if.addr == 8'd11 && bus_if.din[0];
            clr_ov  = bus_if.cs && !bus_if.read_en && bus_if.addr == 8'd11 && bus_if.din[1];
            ovf_hit = !flush && ((m_press & m_pending) != '0);
            if (ovf_hit) m_ovf = 1'b1;
            else if (clr_ov) m_ovf = 1'b0;
            if (flush) begin
                m_fifo.delete();
                m_pending = '0;
            end else begin
                if (pop) void'(m_fifo.pop_front());
                if (m_pending != '0 && m_fifo.size() < DEPTH) begin
                    k = 0;
                    while (!m_pending[k]) k++;
                    m_fifo.push_back(5'(k));
                    m_pending[k] = 1'b0;
                end
                m_pending = m_pending | m_press;
            end
            m_irq   = (m_fifo.size() != 0);
            nstable = m_stable;
            for (int b = 0; b < NK; b++) begin
                all_diff = 1'b1;
                for (int j = 0; j < DEB; j++) begin
                    if (m_hist[m_hist.size() - 2 - j][b] == m_stable[b]) all_diff = 1'b0;
                end
                if (all_diff) nstable[b] = ~m_stable[b];
            end
            m_press  = nstable & ~m_stable;
            m_stable = nstable;
            m_hist.push_back(pb);
            void'(m_hist.pop_front());
        end
    end

    // Every-cycle comparison of the bus outputs against the model
    always @(negedge clk) begin
        if (mvalid) begin
            chk("cyc_dout", bus_if.dout, model_dout());
            chk("cyc_irq", {7'd0, bus_if.irq}, {7'd0, m_irq});
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic lit(input string name, input logic [7:0] ed, input logic ei);
        @(negedge clk);
        chk(name, bus_if.dout, ed);
        chk({name, "_irq"}, {7'd0, bus_if.irq}, {7'd0, ei});
        @(posedge clk);
        #1;
    endtask

    task automatic wr_status(input logic [7:0] d);
        bus_if.addr    = 8'd11;
        bus_if.read_en = 1'b0;
        bus_if.din     = d;
        tick(1);
        bus_if.read_en = 1'b1;
        bus_if.din     = 8'h00;
    endtask

    initial begin
        rst            = 1'b1;
        pb             = '0;
        bus_if.cs      = 1'b1;
        bus_if.read_en = 1'b1;
        bus_if.addr    = 8'd11;
        bus_if.din     = 8'h00;
        tick(3);
        lit("rst_status", 8'h00, 1'b0);
        rst = 1'b0;
        tick(3);
        lit("idle_status", 8'h00, 1'b0);

        // single press of key 5
        pb[5] = 1'b1;
        tick(25);
        lit("t1_status", 8'h11, 1'b1);
        bus_if.addr = 8'd13; lit("t1_live0", 8'h20, 1'b1);
        bus_if.addr = 8'd12; lit("t1_key", 8'h05, 1'b1);
        bus_if.addr = 8'd11; lit("t1_empty", 8'h00, 1'b0);
        pb[5] = 1'b0;
        tick(25);
        bus_if.addr = 8'd13; lit("t1_live0_rel", 8'h00, 1'b0);
        bus_if.addr = 8'd11; lit("t1_no_release_evt", 8'h00, 1'b0);

        // bouncing key 3 never accepted
        for (int i = 0; i < 12; i++) begin
            pb[3] = ~pb[3];
            tick(5);
        end
        pb[3] = 1'b0;
        tick(25);
        lit("t2_status", 8'h00, 1'b0);
        bus_if.addr = 8'd13; lit("t2_live0", 8'h00, 1'b0);
        bus_if.addr = 8'd11;

        // simultaneous presses of keys 2 and 9
        pb[2] = 1'b1; pb[9] = 1'b1;
        tick(25);
        lit("t3_status", 8'h21, 1'b1);
        bus_if.addr = 8'd12;
        lit("t3_key0", 8'h02, 1'b1);
        lit("t3_key1", 8'h09, 1'b1);
        bus_if.addr = 8'd11; lit("t3_empty", 8'h00, 1'b0);
        pb[2] = 1'b0; pb[9] = 1'b0;
        tick(25);

        // fill the FIFO, hold one pending, provoke overflow
        for (int k = 0; k < 9; k++) begin
            pb[k] = 1'b1;
            tick(2);
        end
        tick(25);
        lit("t4_full", 8'h8D, 1'b1);
        bus_if.addr = 8'd13; lit("t4_live0", 8'hFF, 1'b1);
        bus_if.addr = 8'd14; lit("t4_live1", 8'h01, 1'b1);
        bus_if.addr = 8'd11;
        pb[8] = 1'b0;
        tick(25);
        lit("t4_rel8", 8'h8D, 1'b1);
        pb[8] = 1'b1;
        tick(25);
        lit("t4_ovf", 8'h8F, 1'b1);
        bus_if.addr = 8'd12; lit("t4_key", 8'h00, 1'b1);
        bus_if.addr = 8'd11; lit("t4_after_pop", 8'h87, 1'b1);
        wr_status(8'h02);
        lit("t4_ovf_clr", 8'h85, 1'b1);
        pb = '0;
        tick(25);

        // flush, empty KEY read, ignored KEY write
        wr_status(8'h01);
        lit("t5_flush", 8'h00, 1'b0);
        bus_if.addr = 8'd12; lit("t5_key_empty", 8'hFF, 1'b0);
        bus_if.addr = 8'd11; lit("t5_status", 8'h00, 1'b0);
        pb[1] = 1'b1; pb[4] = 1'b1; pb[6] = 1'b1;
        tick(25);
        lit("t5_three", 8'h31, 1'b1);
        bus_if.addr    = 8'd12;
        bus_if.read_en = 1'b0;
        bus_if.din     = 8'h55;
        tick(1);
        bus_if.read_en = 1'b1;
        bus_if.din     = 8'h00;
        bus_if.addr    = 8'd11;
        lit("t5_key_write", 8'h31, 1'b1);
        wr_status(8'h01);
        lit("t5_flush3", 8'h00, 1'b0);
        pb = '0;
        tick(25);

        // reset mid-debounce with codes queued
        pb[7] = 1'b1; pb[10] = 1'b1;
        tick(25);
        lit("t6_two", 8'h21, 1'b1);
        pb[12] = 1'b1;
        tick(8);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        lit("t6_status", 8'h00, 1'b0);
        bus_if.addr = 8'd13; lit("t6_live0", 8'h00, 1'b0);
        bus_if.addr = 8'd14; lit("t6_live1", 8'h00, 1'b0);
        bus_if.addr = 8'd11;
        tick(12);
        lit("t6_still_debouncing", 8'h00, 1'b0);
        tick(10);
        lit("t6_redebounced", 8'h31, 1'b1);
        bus_if.addr = 8'd14; lit("t6_live1_up", 8'h14, 1'b1);
        bus_if.addr = 8'd12;
        lit("t6_key0", 8'h07, 1'b1);
        lit("t6_key1", 8'h0A, 1'b1);
        lit("t6_key2", 8'h0C, 1'b1);
        bus_if.addr = 8'd11; lit("t6_empty", 8'h00, 1'b0);
        pb = '0;
        tick(5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
